sap_control_sequencer: RTL and testbench

Control sequencer for the SAP-1 datapath. Generates the six-phase one-hot timing ring (T1..T6) and decodes the instruction-register opcode into the 12-bit control word. The control word drives the program counter, MAR, RAM, IR, accumulator, B register, adder/subtractor and output register, all of which are built from `dff_posedge` cells and capture on the rising edge of `clk`. Also owns the run/halt state of the machine.

---
 rtl/sap_control_sequencer.sv | 122 ++++++++++++
 tb/tb_sap_control_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sap_control_sequencer.sv
// SAP-1 control sequencer: six-phase one-hot T ring plus opcode decode into the 12-bit control word.
// Latency: con is combinational from the ring and opcode; the ring steps once per enabled rising edge.
// Backpressure: run=0 freezes the ring and blanks con; HLT freezes it permanently until clear_n.
module sap_control_sequencer #(
  parameter logic [3:0] OPC_LDA = 4'h0,
  parameter logic [3:0] OPC_ADD = 4'h1,
  parameter logic [3:0] OPC_SUB = 4'h2,
  parameter logic [3:0] OPC_OUT = 4'hE,
  parameter logic [3:0] OPC_HLT = 4'hF
) (
  input  logic        clk,
  input  logic        clear_n,
  input  logic        run,
  input  logic [3:0]  ir_opcode,
  output logic [11:0] con,
  output logic [5:0]  t_state,
  output logic        halted
);

  // Control word bit positions (all active-high).
  localparam logic [11:0] CP = 12'h800;
  localparam logic [11:0] EP = 12'h400;
  localparam logic [11:0] LM = 12'h200;
  localparam logic [11:0] CE = 12'h100;
  localparam logic [11:0] LI = 12'h080;
  localparam logic [11:0] EI = 12'h040;
  localparam logic [11:0] LA = 12'h020;
  localparam logic [11:0] EA = 12'h010;
  localparam logic [11:0] SU = 12'h008;
  localparam logic [11:0] EU = 12'h004;
  localparam logic [11:0] LB = 12'h002;
  localparam logic [11:0] LO = 12'h001;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  tstate_e state_q, state_d;
  logic    halted_q, halted_d;
  logic    advance;

  // The ring only moves while the machine is running and not halted.
  assign advance = run && !halted_q;

  // Ring and halt flag registers; reset lands in T1, not halted.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= T1;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // Next ring position; HLT in T4 parks the ring at T4 and sets the sticky halt.
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    case (state_q)
      T1: if (advance) state_d = T2;
      T2: if (advance) state_d = T3;
      T3: if (advance) state_d = T4;
      T4: begin
        if (advance) begin
          if (ir_opcode == OPC_HLT) begin
            halted_d = 1'b1;
          end else begin
            state_d = T5;
          end
        end
      end
      T5: if (advance) state_d = T6;
      T6: if (advance) state_d = T1;
      // A corrupted ring is forced back to T1 regardless of run.
      default: state_d = T1;
    endcase
  end

  // Control word decode; blanked whenever no datapath load may happen.
  always_comb begin
    con = 12'h000;
    if (clear_n && run && !halted_q) begin
      case (state_q)
        T1: con = EP | LM;
        T2: con = CP;
        T3: con = CE | LI;
        T4: begin
          if (ir_opcode == OPC_LDA || ir_opcode == OPC_ADD || ir_opcode == OPC_SUB) begin
            con = EI | LM;
          end else if (ir_opcode == OPC_OUT) begin
            con = EA | LO;
          end
        end
        T5: begin
          if (ir_opcode == OPC_LDA) begin
            con = CE | LA;
          end else if (ir_opcode == OPC_ADD || ir_opcode == OPC_SUB) begin
            con = CE | LB;
          end
        end
        T6: begin
          if (ir_opcode == OPC_ADD) begin
            con = EU | LA;
          end else if (ir_opcode == OPC_SUB) begin
            con = SU | EU | LA;
          end
        end
        default: con = 12'h000;
      endcase
    end
  end

  assign t_state = state_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_sap_control_sequencer.sv
module tb_sap_control_sequencer;

  logic        clk;
  logic        clear_n;
  logic        run;
  logic [3:0]  ir_opcode;
  logic [11:0] con;
  logic [5:0]  t_state;
  logic        halted;

  sap_control_sequencer dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .run       (run),
    .ir_opcode (ir_opcode),
    .con       (con),
    .t_state   (t_state),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] con;
    logic [5:0]  t;
    logic        h;
    string       tag;
  } exp_s;

  exp_s exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  event chk_ev;

  // Independent reference for the random section: hand table of the control word.
  function automatic logic [11:0] ref_con(input int ti, input logic [3:0] op, input logic r);
    logic [11:0] c;
    c = 12'h000;
    case (ti)
      0: c = 12'h600;
      1: c = 12'h800;
      2: c = 12'h180;
      3: c = (op == 4'h0 || op == 4'h1 || op == 4'h2) ? 12'h240 : (op == 4'hE ? 12'h011 : 12'h000);
      4: c = (op == 4'h0) ? 12'h120 : ((op == 4'h1 || op == 4'h2) ? 12'h102 : 12'h000);
      5: c = (op == 4'h1) ? 12'h024 : (op == 4'h2 ? 12'h02C : 12'h000);
      default: c = 12'h000;
    endcase
    return r ? c : 12'h000;
  endfunction

  // One clock cycle: after the edge, drive inputs and queue what the DUT must show.
  task automatic cyc(input logic r, input logic [3:0] op, input logic [11:0] ec,
                     input logic [5:0] et, input logic eh, input string tag);
    exp_s e;
    @(posedge clk);
    #1;
    clear_n   = 1'b1;
    run       = r;
    ir_opcode = op;
    e.con = ec; e.t = et; e.h = eh; e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Asynchronous reset in the middle of a cycle, checked before any further edge.
  task automatic rst(input string tag);
    exp_s e;
    @(negedge clk);
    #1;
    clear_n = 1'b0;
    #1;
    e.con = 12'h000; e.t = 6'b000001; e.h = 1'b0; e.tag = tag;
    exp_q.push_back(e);
    ->chk_ev;
  endtask

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per presented sample and compares.
  initial begin
    exp_s e;
    forever begin
      @(negedge clk or chk_ev);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, ".con"}, con, e.con);
        check({e.tag, ".t_state"}, {6'h0, t_state}, {6'h0, e.t});
        check({e.tag, ".halted"}, {11'h0, halted}, {11'h0, e.h});
        check({e.tag, ".onehot"}, {11'h0, $onehot(t_state)}, 12'h001);
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          ti;
    logic        r;
    logic [3:0]  op;
    clear_n   = 1'b0;
    run       = 1'b0;
    ir_opcode = 4'h0;
    repeat (2) @(posedge clk);

    rst("reset0");
    // LDA
    cyc(1, 4'h0, 12'h600, 6'b000001, 0, "lda_t1");
    cyc(1, 4'h0, 12'h800, 6'b000010, 0, "lda_t2");
    cyc(1, 4'h0, 12'h180, 6'b000100, 0, "lda_t3");
    cyc(1, 4'h0, 12'h240, 6'b001000, 0, "lda_t4");
    cyc(1, 4'h0, 12'h120, 6'b010000, 0, "lda_t5");
    cyc(1, 4'h0, 12'h000, 6'b100000, 0, "lda_t6");
    // ADD
    cyc(1, 4'h1, 12'h600, 6'b000001, 0, "add_t1");
    cyc(1, 4'h1, 12'h800, 6'b000010, 0, "add_t2");
    cyc(1, 4'h1, 12'h180, 6'b000100, 0, "add_t3");
    cyc(1, 4'h1, 12'h240, 6'b001000, 0, "add_t4");
    cyc(1, 4'h1, 12'h102, 6'b010000, 0, "add_t5");
    cyc(1, 4'h1, 12'h024, 6'b100000, 0, "add_t6");
    // SUB
    cyc(1, 4'h2, 12'h600, 6'b000001, 0, "sub_t1");
    cyc(1, 4'h2, 12'h800, 6'b000010, 0, "sub_t2");
    cyc(1, 4'h2, 12'h180, 6'b000100, 0, "sub_t3");
    cyc(1, 4'h2, 12'h240, 6'b001000, 0, "sub_t4");
    cyc(1, 4'h2, 12'h102, 6'b010000, 0, "sub_t5");
    cyc(1, 4'h2, 12'h02C, 6'b100000, 0, "sub_t6");
    // OUT
    cyc(1, 4'hE, 12'h600, 6'b000001, 0, "out_t1");
    cyc(1, 4'hE, 12'h800, 6'b000010, 0, "out_t2");
    cyc(1, 4'hE, 12'h180, 6'b000100, 0, "out_t3");
    cyc(1, 4'hE, 12'h011, 6'b001000, 0, "out_t4");
    cyc(1, 4'hE, 12'h000, 6'b010000, 0, "out_t5");
    cyc(1, 4'hE, 12'h000, 6'b100000, 0, "out_t6");
    // Reset mid-T5 of an LDA
    cyc(1, 4'h0, 12'h600, 6'b000001, 0, "ab_t1");
    cyc(1, 4'h0, 12'h800, 6'b000010, 0, "ab_t2");
    cyc(1, 4'h0, 12'h180, 6'b000100, 0, "ab_t3");
    cyc(1, 4'h0, 12'h240, 6'b001000, 0, "ab_t4");
    cyc(1, 4'h0, 12'h120, 6'b010000, 0, "ab_t5");
    rst("reset_mid_t5");
    cyc(1, 4'h0, 12'h600, 6'b000001, 0, "after_rst_t1");
    // HLT with run low in T4: no halt until an edge with run high
    cyc(1, 4'hF, 12'h800, 6'b000010, 0, "hltg_t2");
    cyc(1, 4'hF, 12'h180, 6'b000100, 0, "hltg_t3");
    cyc(0, 4'hF, 12'h000, 6'b001000, 0, "hltg_t4_stop0");
    cyc(0, 4'hF, 12'h000, 6'b001000, 0, "hltg_t4_stop1");
    cyc(1, 4'hF, 12'h000, 6'b001000, 0, "hltg_t4_run");
    cyc(1, 4'hF, 12'h000, 6'b001000, 1, "hltg_halted");
    rst("reset_after_hltg");
    // HLT: held for 20 cycles, then cleared
    cyc(1, 4'hF, 12'h600, 6'b000001, 0, "hlt_t1");
    cyc(1, 4'hF, 12'h800, 6'b000010, 0, "hlt_t2");
    cyc(1, 4'hF, 12'h180, 6'b000100, 0, "hlt_t3");
    cyc(1, 4'hF, 12'h000, 6'b001000, 0, "hlt_t4");
    for (int i = 0; i < 20; i++) cyc(1, 4'hF, 12'h000, 6'b001000, 1, "hlt_hold");
    rst("reset_after_hlt");
    cyc(1, 4'h0, 12'h600, 6'b000001, 0, "hlt_clr_t1");
    // Run gating in T2
    cyc(0, 4'h0, 12'h000, 6'b000010, 0, "gate_t2_a");
    cyc(0, 4'h0, 12'h000, 6'b000010, 0, "gate_t2_b");
    cyc(0, 4'h0, 12'h000, 6'b000010, 0, "gate_t2_c");
    cyc(1, 4'h0, 12'h800, 6'b000010, 0, "gate_t2_resume");
    cyc(1, 4'h0, 12'h180, 6'b000100, 0, "gate_t3");
    cyc(1, 4'h0, 12'h240, 6'b001000, 0, "gate_t4");
    cyc(1, 4'h0, 12'h120, 6'b010000, 0, "gate_t5");
    cyc(1, 4'h0, 12'h000, 6'b100000, 0, "gate_t6");
    // Undefined opcode 5 behaves as NOP
    cyc(1, 4'h5, 12'h600, 6'b000001, 0, "nop_t1");
    cyc(1, 4'h5, 12'h800, 6'b000010, 0, "nop_t2");
    cyc(1, 4'h5, 12'h180, 6'b000100, 0, "nop_t3");
    cyc(1, 4'h5, 12'h000, 6'b001000, 0, "nop_t4");
    cyc(1, 4'h5, 12'h000, 6'b010000, 0, "nop_t5");
    cyc(1, 4'h5, 12'h000, 6'b100000, 0, "nop_t6");
    cyc(1, 4'h0, 12'h600, 6'b000001, 0, "nop_next_t1");
    // Random run/opcode (no HLT); ring advances only on run=1 edges
    ti = 0;
    r  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (r) ti = (ti + 1) % 6;
      r  = 1'($urandom_range(0, 1));
      op = 4'($urandom_range(0, 14));
      cyc(r, op, ref_con(ti, op, r), 6'(1 << ti), 0, "rand");
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
